// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, op encodings and FSM states for the RV32M multiply sequencer
package mul_pkg;
    localparam int XLEN = 32;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI, DONE} state_t;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/response handshake bundle between the execute stage and the multiplier
interface mul_sequencer_if #(parameter int XLEN = mul_pkg::XLEN);
    logic            kill;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    modport master (output kill, in_valid, op, a, b, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  kill, in_valid, op, a, b, out_ready,
                    output in_ready, out_valid, result, busy);
endinterface

// File: rtl/mul_sequencer_adder.sv
// mul_sequencer_adder: ripple-carry adder with carry in/out
module mul_sequencer_adder #(parameter int SIZE = 32) (
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout
);
    logic c;
    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < SIZE; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: fixed-latency RV32M multiplier built around one shared ripple-carry adder
module mul_sequencer import mul_pkg::*; #(parameter int XLEN = mul_pkg::XLEN) (
    input  logic           clk,
    input  logic           rst_n,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    state_t state, nxt;
    logic [1:0] op_r;
    logic sign_a, sign_b, neg, carry, acin, cout, sa, sb;
    logic [XLEN-1:0] mcand, acc_lo, acc_hi, ax, ay, s;
    logic [CW-1:0] cnt;
    assign sa = bus.a[XLEN-1] & (bus.op == OP_MULH || bus.op == OP_MULHSU);
    assign sb = bus.b[XLEN-1] & (bus.op == OP_MULH);
    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.result    = bus.out_valid ? (op_r == OP_MUL ? acc_lo : acc_hi) : '0;
    mul_sequencer_adder #(.SIZE(XLEN)) u_add (.x(ax), .y(ay), .cin(acin), .s(s), .cout(cout));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = bus.in_valid ? PREP_A : IDLE;
            PREP_A:  nxt = PREP_B;
            PREP_B:  nxt = ITER;
            ITER:    nxt = cnt == CW'(XLEN - 1) ? FIX_LO : ITER;
            FIX_LO:  nxt = FIX_HI;
            FIX_HI:  nxt = DONE;
            DONE:    nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        if (bus.kill) nxt = IDLE;
    end
    // operand mux for the shared adder; idle states add 0+0
    always_comb begin
        ax = '0;
        ay = '0;
        acin = 1'b0;
        unique case (state)
            PREP_A: begin ax = sign_a ? ~mcand : mcand; acin = sign_a; end
            PREP_B: begin ax = sign_b ? ~acc_lo : acc_lo; acin = sign_b; end
            ITER:   begin ax = acc_hi; ay = acc_lo[0] ? mcand : '0; end
            FIX_LO: begin ax = neg ? ~acc_lo : acc_lo; acin = neg; end
            FIX_HI: begin ax = neg ? ~acc_hi : acc_hi; acin = neg & carry; end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_r <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            neg <= 1'b0;
            carry <= 1'b0;
            mcand <= '0;
            acc_lo <= '0;
            acc_hi <= '0;
            cnt <= '0;
        end else if (!bus.kill) begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    op_r <= bus.op;
                    mcand <= bus.a;
                    acc_lo <= bus.b;
                    sign_a <= sa;
                    sign_b <= sb;
                    neg <= sa ^ sb;
                end
                PREP_A: mcand <= s;
                PREP_B: begin
                    acc_lo <= s;
                    acc_hi <= '0;
                    cnt <= '0;
                end
                ITER: begin
                    acc_hi <= {cout, s[XLEN-1:1]};
                    acc_lo <= {s[0], acc_lo[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                end
                FIX_LO: begin
                    acc_lo <= s;
                    carry <= cout;
                end
                FIX_HI: acc_hi <= s;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench comparing the sequencer with a wide-arithmetic reference
module tb_mul_sequencer;
    logic clk = 0;
    logic rst_n = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    mul_sequencer_if bus();
    mul_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        logic signed [65:0] ex, ey, p;
        ex = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'b0, x};
        ey = (o == 2'b01) ? {{34{y[31]}}, y} : {34'b0, y};
        p = ex * ey;
        return o == 2'b00 ? p[31:0] : p[63:32];
    endfunction

    function automatic void check(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endfunction

    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%h required=none", bus.result);
            end else check("result", bus.result, q.pop_front());
        end

    task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        int n = 0;
        @(posedge clk); #1;
        bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1;
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("accept_timeout", 0, 1);
        q.push_back(model(o, x, y));
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic run_op(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        int lat = -1, bn = 0, ov = 0;
        issue(o, x, y);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.out_valid && lat < 0) lat = k;
            if (bus.busy) bn++;
            if (bus.out_valid) ov++;
            if (!bus.busy) break;
        end
        check("latency", lat, 36);
        check("busy_cycles", bn, 37);
        check("valid_cycles", ov, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pick [4];
        int lat;
        bus.kill = 0; bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.out_ready = 1;
        #23;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        @(negedge clk) rst_n = 1;

        run_op(2'b00, 32'd7, 32'd6);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b01, 32'h80000000, 32'h80000000);
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000001);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b01, 32'h00000000, 32'h80000000);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] x, y;
            pick[0] = 0; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000; pick[3] = $urandom;
            x = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            run_op(2'($urandom_range(0, 3)), x, y);
        end

        // backpressure: result must hold and new requests must be refused
        bus.out_ready = 0;
        issue(2'b00, 32'd3, 32'd5);
        lat = -1;
        for (int k = 0; k < 200 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) lat = k;
        end
        check("bp_latency", lat, 36);
        bus.op = 2'b11; bus.a = $urandom; bus.b = $urandom; bus.in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_result", bus.result, 32'h0000000F);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 0; bus.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", bus.in_ready, 1);
        check("bp_idle_busy", bus.busy, 0);
        @(negedge clk);
        check("bp_no_accept", bus.busy, 0);

        // kill on the tenth ITER cycle
        issue(2'b00, 32'h12345678, 32'h00005678);
        repeat (11) @(posedge clk);
        #1;
        check("kill_pre_busy", bus.busy, 1);
        bus.kill = 1;
        @(posedge clk); #1;
        bus.kill = 0;
        void'(q.pop_back());
        @(negedge clk);
        check("kill_in_ready", bus.in_ready, 1);
        check("kill_busy", bus.busy, 0);
        lat = 0;
        repeat (40) begin @(negedge clk); if (bus.out_valid) lat++; end
        check("kill_no_valid", lat, 0);
        run_op(2'b00, 32'd3, 32'd5);

        // kill together with an accept: nothing latched
        @(posedge clk); #1;
        bus.op = 2'b00; bus.a = 9; bus.b = 9; bus.in_valid = 1; bus.kill = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.kill = 0;
        @(negedge clk);
        check("kill_accept_busy", bus.busy, 0);

        // asynchronous reset mid-operation
        issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
        repeat (15) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_result", bus.result, 0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        run_op(2'b11, 32'h00010000, 32'h00010000);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
